// File: rtl/daq_gtx_tx_init_ctrl_pkg.sv
// Shared definitions for the GTX TX bring-up sequencer: state encoding,
// timer width and the per-state reset/status output decode.
package daq_gtx_tx_init_ctrl_pkg;

    localparam int TIMER_W = 16;

    // Encoding is visible on STATE for VME readback, so values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_DIV_INIT  = 3'd3,
        ST_TX_RST    = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_READY     = 3'd6,
        ST_FAULT     = 3'd7
    } state_t;

    typedef struct packed {
        logic gtxreset;
        logic txreset;
        logic tx_ready;
        logic fault;
    } state_outs_t;

    function automatic state_outs_t decode_outs(state_t s);
        state_outs_t o;
        o.gtxreset = (s == ST_IDLE) || (s == ST_PLL_RST) || (s == ST_FAULT);
        o.txreset  = (s != ST_WAIT_DONE) && (s != ST_READY);
        o.tx_ready = (s == ST_READY);
        o.fault    = (s == ST_FAULT);
        return o;
    endfunction

endpackage

// File: rtl/daq_gtx_tx_init_ctrl_sync_2ff.sv
// Two-flop synchroniser for single-bit GTX status levels into the CLK domain.
module sync_2ff (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/daq_gtx_tx_init_ctrl.sv
// GTX TX reset/bring-up sequencer: PLL reset, divider INIT, TX reset, then
// READY, with automatic bounded-retry recovery and a sticky FAULT state.
module daq_gtx_tx_init_ctrl
    import daq_gtx_tx_init_ctrl_pkg::*;
#(
    parameter logic [TIMER_W-1:0] RESET_HOLD   = 16'd64,
    parameter logic [TIMER_W-1:0] LOCK_TIMEOUT = 16'd40000,
    parameter logic [TIMER_W-1:0] DIV_TIMEOUT  = 16'd4096,
    parameter logic [TIMER_W-1:0] DONE_TIMEOUT = 16'd8192,
    parameter logic [3:0]         MAX_RETRIES  = 4'd7
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       ENABLE,
    input  logic       FORCE_REINIT,
    input  logic       PLLLKDET,
    input  logic       TXRESETDONE,
    input  logic       GTXTEST_DONE,
    input  logic [1:0] TXBUFSTATUS,
    output logic       GTXRESET,
    output logic       TXRESET,
    output logic       INIT,
    output logic       TX_READY,
    output logic       FAULT,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] BUF_ERR_CNT,
    output logic [2:0] STATE
);
    state_t               state, nxt;
    logic [TIMER_W-1:0]   timer, tmr_load;
    logic [1:0]           async_in, synced;
    logic                 lock_sync, done_sync, tmr_zero;
    logic                 restart, retry_req, retry_clr, retry_inc, buf_inc;
    logic                 unused_bufstatus;

    assign async_in         = {TXRESETDONE, PLLLKDET};
    assign lock_sync        = synced[0];
    assign done_sync        = synced[1];
    assign unused_bufstatus = TXBUFSTATUS[0];

    for (genvar i = 0; i < 2; i++) begin : g_sync
        sync_2ff u_sync (
            .CLK   (CLK),
            .RST_N (RST_N),
            .d     (async_in[i]),
            .q     (synced[i])
        );
    end

    assign tmr_zero = (timer == '0);

    // Branch order encodes priority: disable > reinit > lock loss > buffer error > timeout > progress.
    always_comb begin
        nxt       = state;
        restart   = 1'b0;
        retry_req = 1'b0;
        retry_clr = 1'b0;
        retry_inc = 1'b0;
        buf_inc   = 1'b0;
        if (!ENABLE) begin
            nxt       = ST_IDLE;
            retry_clr = 1'b1;
        end else if (FORCE_REINIT) begin
            nxt       = ST_PLL_RST;
            retry_clr = 1'b1;
            restart   = 1'b1;
        end else begin
            case (state)
                ST_IDLE:      nxt = ST_PLL_RST;
                ST_PLL_RST:   if (tmr_zero) nxt = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (tmr_zero)       retry_req = 1'b1;
                    else if (lock_sync) nxt = ST_DIV_INIT;
                end
                ST_DIV_INIT: begin
                    if (!lock_sync || tmr_zero) retry_req = 1'b1;
                    else if (GTXTEST_DONE)      nxt = ST_TX_RST;
                end
                ST_TX_RST:    if (tmr_zero) nxt = ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (tmr_zero)       retry_req = 1'b1;
                    else if (done_sync) nxt = ST_READY;
                end
                ST_READY: begin
                    if (!lock_sync) retry_req = 1'b1;
                    else if (TXBUFSTATUS[1]) begin
                        nxt     = ST_TX_RST;
                        buf_inc = 1'b1;
                    end
                end
                default: nxt = state;
            endcase
            if (retry_req) begin
                restart = 1'b1;
                if (RETRY_CNT == MAX_RETRIES) begin
                    nxt = ST_FAULT;
                end else begin
                    nxt       = ST_PLL_RST;
                    retry_inc = 1'b1;
                end
            end
        end
    end

    // Hold states count RESET_HOLD-1 down to 0; wait states give the full timeout to succeed.
    always_comb begin
        tmr_load = '0;
        case (nxt)
            ST_PLL_RST, ST_TX_RST: tmr_load = RESET_HOLD - TIMER_W'(1);
            ST_WAIT_LOCK:          tmr_load = LOCK_TIMEOUT;
            ST_DIV_INIT:           tmr_load = DIV_TIMEOUT;
            ST_WAIT_DONE:          tmr_load = DONE_TIMEOUT;
            default:               tmr_load = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            timer       <= '0;
            GTXRESET    <= 1'b1;
            TXRESET     <= 1'b1;
            INIT        <= 1'b0;
            TX_READY    <= 1'b0;
            FAULT       <= 1'b0;
            RETRY_CNT   <= 4'd0;
            BUF_ERR_CNT <= 8'd0;
        end else begin
            state                               <= nxt;
            {GTXRESET, TXRESET, TX_READY, FAULT} <= decode_outs(nxt);
            INIT                                <= (nxt == ST_DIV_INIT) && (state != ST_DIV_INIT);
            if ((nxt != state) || restart)
                timer <= tmr_load;
            else if (!tmr_zero)
                timer <= timer - TIMER_W'(1);
            if (retry_clr)
                RETRY_CNT <= 4'd0;
            else if (retry_inc)
                RETRY_CNT <= RETRY_CNT + 4'd1;
            if (buf_inc && (BUF_ERR_CNT != 8'hFF))
                BUF_ERR_CNT <= BUF_ERR_CNT + 8'd1;
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_daq_gtx_tx_init_ctrl.sv
// Bench for the GTX TX bring-up sequencer: directed scenarios plus a random
// soak, every cycle checked against a cycle-counting behavioural model.
module tb_daq_gtx_tx_init_ctrl;
    localparam logic [15:0] P_HOLD = 16'd64;
    localparam logic [15:0] P_LOCK = 16'd300;
    localparam logic [15:0] P_DIV  = 16'd200;
    localparam logic [15:0] P_DONE = 16'd200;
    localparam logic [3:0]  P_MAXR = 4'd2;

    localparam int M_IDLE = 0, M_PLL = 1, M_WLOCK = 2, M_DINIT = 3;
    localparam int M_TXRST = 4, M_WDONE = 5, M_READY = 6, M_FAULT = 7;

    logic       CLK = 1'b0, RST_N = 1'b0, ENABLE = 1'b0, FORCE_REINIT = 1'b0;
    logic       PLLLKDET = 1'b0, TXRESETDONE = 1'b0, GTXTEST_DONE = 1'b0;
    logic [1:0] TXBUFSTATUS = 2'b00;
    logic       GTXRESET, TXRESET, INIT, TX_READY, FAULT;
    logic [3:0] RETRY_CNT;
    logic [7:0] BUF_ERR_CNT;
    logic [2:0] STATE;

    daq_gtx_tx_init_ctrl #(
        .RESET_HOLD(P_HOLD), .LOCK_TIMEOUT(P_LOCK), .DIV_TIMEOUT(P_DIV),
        .DONE_TIMEOUT(P_DONE), .MAX_RETRIES(P_MAXR)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .FORCE_REINIT(FORCE_REINIT),
        .PLLLKDET(PLLLKDET), .TXRESETDONE(TXRESETDONE), .GTXTEST_DONE(GTXTEST_DONE),
        .TXBUFSTATUS(TXBUFSTATUS), .GTXRESET(GTXRESET), .TXRESET(TXRESET), .INIT(INIT),
        .TX_READY(TX_READY), .FAULT(FAULT), .RETRY_CNT(RETRY_CNT),
        .BUF_ERR_CNT(BUF_ERR_CNT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    int vecs = 0, misc = 0;
    int init_seen = 0, gtx_hi = 0;

    // Model: phase, cycles spent in phase, retry/buffer counts, 2-deep input delay lines.
    int     m_ph, m_t, m_rc, m_bc;
    bit     m_init;
    bit [1:0] m_lk, m_dn;

    task automatic m_reset();
        m_ph = M_IDLE; m_t = 0; m_rc = 0; m_bc = 0; m_init = 0; m_lk = 2'b00; m_dn = 2'b00;
    endtask

    task automatic m_step();
        bit lk, dn, retry, restart;
        int np;
        lk = m_lk[1];
        dn = m_dn[1];
        m_lk = {m_lk[0], PLLLKDET};
        m_dn = {m_dn[0], TXRESETDONE};
        np = m_ph; retry = 0; restart = 0;
        if (!ENABLE) begin
            np = M_IDLE; m_rc = 0;
        end else if (FORCE_REINIT) begin
            np = M_PLL; m_rc = 0; restart = 1;
        end else begin
            case (m_ph)
                M_IDLE:  np = M_PLL;
                M_PLL:   if (m_t == int'(P_HOLD) - 1) np = M_WLOCK;
                M_WLOCK: if (m_t == int'(P_LOCK)) retry = 1; else if (lk) np = M_DINIT;
                M_DINIT: if (!lk || m_t == int'(P_DIV)) retry = 1; else if (GTXTEST_DONE) np = M_TXRST;
                M_TXRST: if (m_t == int'(P_HOLD) - 1) np = M_WDONE;
                M_WDONE: if (m_t == int'(P_DONE)) retry = 1; else if (dn) np = M_READY;
                M_READY: if (!lk) retry = 1;
                         else if (TXBUFSTATUS[1]) begin
                             np = M_TXRST;
                             if (m_bc < 255) m_bc++;
                         end
                default: ;
            endcase
            if (retry) begin
                restart = 1;
                if (m_rc == int'(P_MAXR)) np = M_FAULT;
                else begin m_rc++; np = M_PLL; end
            end
        end
        m_init = (np == M_DINIT) && (m_ph != M_DINIT);
        m_t    = (np != m_ph || restart) ? 0 : m_t + 1;
        m_ph   = np;
    endtask

    task automatic cmp1(string nm, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        cmp1(nm, act, exp);
    endtask

    task automatic compare();
        vecs++;
        cmp1("STATE",       32'(STATE),       32'(m_ph));
        cmp1("GTXRESET",    32'(GTXRESET),    32'(m_ph == M_IDLE || m_ph == M_PLL || m_ph == M_FAULT));
        cmp1("TXRESET",     32'(TXRESET),     32'(!(m_ph == M_WDONE || m_ph == M_READY)));
        cmp1("TX_READY",    32'(TX_READY),    32'(m_ph == M_READY));
        cmp1("FAULT",       32'(FAULT),       32'(m_ph == M_FAULT));
        cmp1("INIT",        32'(INIT),        32'(m_init));
        cmp1("RETRY_CNT",   32'(RETRY_CNT),   32'(m_rc));
        cmp1("BUF_ERR_CNT", 32'(BUF_ERR_CNT), 32'(m_bc));
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST_N) m_step(); else m_reset();
        @(negedge CLK);
        compare();
        if (INIT === 1'b1) init_seen++;
        if (GTXRESET === 1'b1) gtx_hi++;
    endtask

    task automatic wait_ph(int ph, int budget, string nm);
        int n;
        n = 0;
        while (m_ph != ph && n < budget) begin tick(); n++; end
        chk(nm, 32'(STATE), 32'(ph));
    endtask

    task automatic wait_init(int budget, string nm);
        int n;
        n = 0;
        while (!m_init && n < budget) begin tick(); n++; end
        chk(nm, 32'(INIT), 32'd1);
    endtask

    task automatic wait_retry(int rc, int budget, string nm);
        int n;
        n = 0;
        while (m_rc != rc && n < budget) begin tick(); n++; end
        chk(nm, 32'(RETRY_CNT), 32'(rc));
    endtask

    task automatic pulse_test_done();
        GTXTEST_DONE = 1'b1; tick(); GTXTEST_DONE = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        repeat (3) tick();
        chk("rst_state",    32'(STATE),       32'd0);
        chk("rst_gtxreset", 32'(GTXRESET),    32'd1);
        chk("rst_txreset",  32'(TXRESET),     32'd1);
        chk("rst_bufcnt",   32'(BUF_ERR_CNT), 32'd0);
        RST_N = 1'b1;
        repeat (2) tick();

        // Nominal bring-up
        ENABLE = 1'b1; init_seen = 0; gtx_hi = 0;
        repeat (100) tick();
        PLLLKDET = 1'b1;
        wait_init(200, "nom_init");
        repeat (49) tick();
        pulse_test_done();
        repeat (29) tick();
        TXRESETDONE = 1'b1;
        wait_ph(M_READY, 300, "nom_ready");
        chk("nom_tx_ready",  32'(TX_READY),  32'd1);
        chk("nom_retry",     32'(RETRY_CNT), 32'd0);
        chk("nom_init_once", 32'(init_seen), 32'd1);
        chk("nom_gtx_hold",  32'(gtx_hi),    32'd64);

        // Lock never arrives: three WAIT_LOCK timeouts then FAULT
        PLLLKDET = 1'b0; TXRESETDONE = 1'b0;
        FORCE_REINIT = 1'b1; tick(); FORCE_REINIT = 1'b0;
        wait_ph(M_FAULT, 2000, "nolock_fault");
        chk("nolock_fault_o", 32'(FAULT),     32'd1);
        chk("nolock_retry",   32'(RETRY_CNT), 32'd2);
        chk("nolock_gtxrst",  32'(GTXRESET),  32'd1);
        repeat (5) tick();
        chk("fault_sticky",   32'(STATE),     32'd7);
        FORCE_REINIT = 1'b1; tick(); FORCE_REINIT = 1'b0;
        chk("reinit_state",   32'(STATE),     32'd1);
        chk("reinit_fault",   32'(FAULT),     32'd0);
        chk("reinit_retry",   32'(RETRY_CNT), 32'd0);

        // One retry, then up; buffer error recovery keeps RETRY_CNT
        wait_retry(1, 500, "late_lock_retry");
        PLLLKDET = 1'b1;
        wait_init(500, "s3_init");
        pulse_test_done();
        TXRESETDONE = 1'b1;
        wait_ph(M_READY, 300, "s3_ready");
        TXBUFSTATUS = 2'b10; tick(); TXBUFSTATUS = 2'b00;
        chk("buf_state",  32'(STATE),       32'd4);
        chk("buf_ready",  32'(TX_READY),    32'd0);
        chk("buf_cnt",    32'(BUF_ERR_CNT), 32'd1);
        chk("buf_retry",  32'(RETRY_CNT),   32'd1);
        wait_ph(M_READY, 300, "buf_recover");

        // Lock loss and buffer error reach the FSM together: lock loss wins
        PLLLKDET = 1'b0; tick(); tick();
        TXBUFSTATUS = 2'b10; tick(); TXBUFSTATUS = 2'b00;
        chk("both_state", 32'(STATE),       32'd1);
        chk("both_retry", 32'(RETRY_CNT),   32'd2);
        chk("both_buf",   32'(BUF_ERR_CNT), 32'd1);

        // Async reset mid WAIT_DONE
        PLLLKDET = 1'b1; TXRESETDONE = 1'b0;
        wait_init(500, "s5_init");
        pulse_test_done();
        wait_ph(M_WDONE, 200, "s5_wdone");
        repeat (5) tick();
        #2 RST_N = 1'b0;
        #1 m_reset();
        compare();
        chk("arst_state", 32'(STATE),       32'd0);
        chk("arst_gtx",   32'(GTXRESET),    32'd1);
        chk("arst_tx",    32'(TXRESET),     32'd1);
        chk("arst_rdy",   32'(TX_READY),    32'd0);
        chk("arst_buf",   32'(BUF_ERR_CNT), 32'd0);
        repeat (2) tick();
        RST_N = 1'b1; PLLLKDET = 1'b0;
        wait_ph(M_WLOCK, 100, "s5_wlock");
        pulse_test_done();
        wait_retry(1, 500, "s5_retry");
        PLLLKDET = 1'b1;
        wait_ph(M_DINIT, 500, "s5_dinit");
        repeat (3) tick();
        chk("early_done_ignored", 32'(STATE), 32'd3);
        ENABLE = 1'b0; tick();
        chk("dis_state", 32'(STATE),     32'd0);
        chk("dis_retry", 32'(RETRY_CNT), 32'd0);

        // Random soak
        ENABLE = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            FORCE_REINIT = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 199) == 0) PLLLKDET = 1'b0;
            else if ($urandom_range(0, 19) == 0) PLLLKDET = 1'b1;
            if ($urandom_range(0, 149) == 0) TXRESETDONE = 1'b0;
            else if ($urandom_range(0, 9) == 0) TXRESETDONE = 1'b1;
            GTXTEST_DONE = ($urandom_range(0, 29) == 0);
            TXBUFSTATUS  = {($urandom_range(0, 119) == 0), 1'($urandom_range(0, 1))};
            ENABLE       = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
        $finish;
    end
endmodule
